seq_gen: RTL

//  Serial pattern transmitter. The driving end of the seqcheck serial line: it emits a

---
 rtl/seqcheck_pkg.sv | 15 +
 rtl/seq_shreg.sv | 30 +++
 rtl/seq_gen.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/seqcheck_pkg.sv
// Shared definitions for the seqcheck serial line (seq_gen transmitter, seq_check receiver).
package seqcheck_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap,
    StDone
  } seq_state_e;

  localparam int unsigned PatWDefault = 8;
  localparam int unsigned RepWDefault = 4;
  localparam int unsigned GapDefault  = 2;

endpackage

// File: rtl/seq_shreg.sv
// Loadable left-shift register; the serial bit is always the MSB of the stored word.
module seq_shreg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb_out
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (clear) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= din;
    end else if (shift) begin
      data_q <= {data_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb_out = data_q[WIDTH-1];

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends pat MSB-first, reps copies separated by GAP idle cycles.
module seq_gen
  import seqcheck_pkg::*;
#(
  parameter int unsigned PAT_W = PatWDefault,
  parameter int unsigned REP_W = RepWDefault,
  parameter int unsigned GAP   = GapDefault
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [PAT_W-1:0]           pat,
  input  logic [$clog2(PAT_W+1)-1:0] pat_len,
  input  logic [REP_W-1:0]           reps,
  input  logic                       abort,
  output logic                       out_sig,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned LenW = $clog2(PAT_W + 1);
  localparam int unsigned GapW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  seq_state_e       state_q;
  logic [PAT_W-1:0] pat_q;
  logic [LenW-1:0]  len_q;
  logic [LenW-1:0]  bit_cnt_q;
  logic [REP_W-1:0] rep_cnt_q;
  logic [GapW-1:0]  gap_cnt_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             done_q;

  logic             len_ok;
  logic             accept;
  logic             sh_clear;
  logic             sh_load;
  logic             sh_shift;
  logic [PAT_W-1:0] sh_din;

  // Left-align the pattern so its first bit (p[l-1]) sits in the register MSB.
  function automatic logic [PAT_W-1:0] align(input logic [PAT_W-1:0] p, input logic [LenW-1:0] l);
    return p << (LenW'(PAT_W) - l);
  endfunction

  assign len_ok = (pat_len != '0) && (pat_len <= LenW'(PAT_W));
  // DONE samples start like IDLE so back-to-back transfers have no dead cycle.
  assign accept = start && len_ok && (reps != '0) &&
                  ((state_q == StIdle) || ((state_q == StDone) && !abort));

  always_comb begin
    sh_clear = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_din   = align(pat_q, len_q);
    if (accept) begin
      sh_load = 1'b1;
      sh_din  = align(pat, pat_len);
    end else begin
      unique case (state_q)
        StShift: begin
          if (abort) begin
            sh_clear = 1'b1;
          end else if (bit_cnt_q > LenW'(1)) begin
            sh_shift = 1'b1;
          end else if ((rep_cnt_q > REP_W'(1)) && (GAP == 0)) begin
            sh_load = 1'b1;
          end else begin
            sh_clear = 1'b1;
          end
        end
        StGap: begin
          if (abort) begin
            sh_clear = 1'b1;
          end else if (gap_cnt_q <= GapW'(1)) begin
            sh_load = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  seq_shreg #(
    .WIDTH (PAT_W)
  ) u_shreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (sh_clear),
    .load    (sh_load),
    .shift   (sh_shift),
    .din     (sh_din),
    .msb_out (out_sig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pat_q       <= '0;
      len_q       <= '0;
      bit_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q     <= StShift;
        pat_q       <= pat;
        len_q       <= pat_len;
        bit_cnt_q   <= pat_len;
        rep_cnt_q   <= reps;
        gap_cnt_q   <= '0;
        out_valid_q <= 1'b1;
        busy_q      <= 1'b1;
      end else if (abort && (state_q != StIdle)) begin
        state_q     <= StIdle;
        bit_cnt_q   <= '0;
        rep_cnt_q   <= '0;
        gap_cnt_q   <= '0;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        unique case (state_q)
          StShift: begin
            if (bit_cnt_q > LenW'(1)) begin
              bit_cnt_q <= bit_cnt_q - LenW'(1);
            end else if (rep_cnt_q > REP_W'(1)) begin
              rep_cnt_q <= rep_cnt_q - REP_W'(1);
              if (GAP == 0) begin
                bit_cnt_q <= len_q;
              end else begin
                state_q     <= StGap;
                gap_cnt_q   <= GapW'(GAP);
                out_valid_q <= 1'b0;
              end
            end else begin
              state_q     <= StDone;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end
          end
          StGap: begin
            if (gap_cnt_q > GapW'(1)) begin
              gap_cnt_q <= gap_cnt_q - GapW'(1);
            end else begin
              state_q     <= StShift;
              gap_cnt_q   <= '0;
              bit_cnt_q   <= len_q;
              out_valid_q <= 1'b1;
            end
          end
          StDone: begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            busy_q    <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
